// File: rtl/rtc_bus_arbiter_pkg.sv
// Shared types, register address constants and sizing helpers for the RTC bus arbiter.
package rtc_bus_arbiter_pkg;

  // Arbiter FSM states; encodings are shared with the other RTC bus users.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StGuard = 2'd3
  } arb_state_e;

  // RTC register addresses used by the requesters.
  localparam logic [7:0] RtcAddrMinutes = 8'h21;
  localparam logic [7:0] RtcAddrCtrl    = 8'hF0;

  // Width of a counter that must hold 0..max_val, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Width of an index into n items, never narrower than 1 bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rtc_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last', wrapping.
module rtc_bus_arbiter_rr_pick
  import rtc_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] winner,
  output logic [IW-1:0]    winner_idx
);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;
  logic          found;

  // Scan requesters starting one past the previous owner; the first hit wins.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand     = (32'(last) + k) % N_REQ;
      cand_idx = IW'(cand);
      if (!found && req[cand_idx]) begin
        found              = 1'b1;
        winner[cand_idx]   = 1'b1;
        winner_idx         = cand_idx;
      end
    end
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Round-robin arbiter sharing one RTC bus driver: one transaction at a time, guard gap
// after each transaction, timeout abort while waiting for the driver.
module rtc_bus_arbiter
  import rtc_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 8,
  parameter int unsigned GUARD_CYC   = 4,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  wr,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]  gnt,
  output logic [N_REQ-1:0]  ack,
  output logic [N_REQ-1:0]  err,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic              bus_start,
  output logic              bus_wr,
  output logic [AW-1:0]     bus_addr,
  output logic [DW-1:0]     bus_wdata,
  input  logic [DW-1:0]     bus_rdata,
  input  logic              bus_done
);

  localparam int unsigned IW = idx_width(N_REQ);
  localparam int unsigned TW = cnt_width(TIMEOUT_CYC);
  localparam int unsigned GW = cnt_width(GUARD_CYC);
  localparam logic [IW-1:0] LastRst = IW'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             bus_wr_q, bus_wr_d;
  logic [AW-1:0]    bus_addr_q, bus_addr_d;
  logic [DW-1:0]    bus_wdata_q, bus_wdata_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [GW-1:0]    guard_q, guard_d;

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic [AW-1:0]    addr_sel;
  logic [DW-1:0]    wdata_sel;

  rtc_bus_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req        (req),
    .last       (last_q),
    .winner     (pick_oh),
    .winner_idx (pick_idx)
  );

  // Select the winning requester's address and write data slices.
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        addr_sel  = addr[i*AW +: AW];
        wdata_sel = wdata[i*DW +: DW];
      end
    end
  end

  // Next-state logic for the FSM, latches, timeout and guard counters.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    err_d       = '0;
    rdata_d     = rdata_q;
    bus_wr_d    = bus_wr_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    timer_d     = timer_q;
    guard_d     = guard_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d       = pick_oh;
          last_d      = pick_idx;
          bus_wr_d    = wr[pick_idx];
          bus_addr_d  = addr_sel;
          bus_wdata_d = wdata_sel;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        // Done is checked first so a completion on the expiry cycle still acks.
        if (bus_done) begin
          if (!bus_wr_q) rdata_d = bus_rdata;
          ack_d   = gnt_q;
          guard_d = '0;
          state_d = StGuard;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          err_d   = gnt_q;
          guard_d = '0;
          state_d = StGuard;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StGuard: begin
        // First guard cycle carries the ack/err pulse; grant drops after it.
        gnt_d = '0;
        if ((GUARD_CYC == 0) || (guard_q == GW'(GUARD_CYC - 1))) begin
          state_d = StIdle;
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset aborts any transaction and rewinds the pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      last_q      <= LastRst;
      gnt_q       <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      timer_q     <= '0;
      guard_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      bus_wr_q    <= bus_wr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      timer_q     <= timer_d;
      guard_q     <= guard_d;
    end
  end

  // Output decode.
  always_comb begin
    gnt       = gnt_q;
    ack       = ack_q;
    err       = err_q;
    rdata     = rdata_q;
    busy      = (state_q != StIdle);
    bus_start = (state_q == StIssue);
    bus_wr    = bus_wr_q;
    bus_addr  = bus_addr_q;
    bus_wdata = bus_wdata_q;
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter with default parameters (3 requesters, guard 4,
// timeout 1023). Inputs are driven and outputs sampled 2 time units after each rising edge.
module tb_rtc_bus_arbiter;
  import rtc_bus_arbiter_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  wr;
  logic [23:0] addr;
  logic [23:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [7:0]  rdata;
  logic        busy;
  logic        bus_start;
  logic        bus_wr;
  logic [7:0]  bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_done;

  int n_cmp;
  int n_err;
  int start_cnt;
  int g2_cnt;
  int viol_cnt;

  rtc_bus_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .bus_start (bus_start),
    .bus_wr    (bus_wr),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_done  (bus_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Background monitors: start strobes, grants to requester 2, one-hot violations.
  always @(negedge clk) begin
    if (reset) begin
      if (bus_start) start_cnt++;
      if (gnt[2]) g2_cnt++;
      if ($countones(gnt) > 1 || $countones(ack) > 1 || $countones(err) > 1 ||
          ((|ack) && (|err)))
        viol_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (bus_start !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    chk(tag, 32'(bus_start), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 64) begin
      step();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  // Waits for the strobe, returns done 'dly' cycles after it, checks the ack.
  task automatic serve(input int dly, input logic [7:0] rd, output logic [2:0] g);
    wait_start("serve_start");
    g = gnt;
    repeat (dly) step();
    bus_done  = 1'b1;
    bus_rdata = rd;
    step();
    bus_done = 1'b0;
    chk("serve_ack", 32'(ack), 32'(g));
  endtask

  initial begin
    logic [2:0] g;
    int n;
    int s0;
    int g0;
    n_cmp = 0;
    n_err = 0;
    start_cnt = 0;
    g2_cnt = 0;
    viol_cnt = 0;
    reset = 1'b0;
    req = '0;
    wr = '0;
    addr = '0;
    wdata = '0;
    bus_rdata = '0;
    bus_done = 1'b0;

    // Reset state
    #3;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(bus_start), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    step();
    reset = 1'b1;
    step();

    // 1. Single read from requester 0
    req = 3'b001;
    wr = 3'b000;
    addr[7:0] = RtcAddrMinutes;
    step();
    chk("t1_gnt", 32'(gnt), 32'b001);
    chk("t1_start", 32'(bus_start), 32'd1);
    chk("t1_addr", 32'(bus_addr), 32'h21);
    chk("t1_wr", 32'(bus_wr), 32'd0);
    repeat (5) step();
    chk("t1_nostart", 32'(bus_start), 32'd0);
    bus_done = 1'b1;
    bus_rdata = 8'h37;
    step();
    bus_done = 1'b0;
    req = 3'b000;
    chk("t1_ack", 32'(ack), 32'b001);
    chk("t1_rdata", 32'(rdata), 32'h37);
    chk("t1_gnt_ackcyc", 32'(gnt), 32'b001);
    step();
    chk("t1_ack_pulse", 32'(ack), 32'd0);
    chk("t1_gnt_drop", 32'(gnt), 32'd0);
    step();
    step();
    chk("t1_busy_guard", 32'(busy), 32'd1);
    step();
    chk("t1_busy_low", 32'(busy), 32'd0);
    chk("t1_start_cnt", 32'(start_cnt), 32'd1);

    // 2. Contention from reset: order 0,1,2,0
    reset = 1'b0;
    #1;
    reset = 1'b1;
    addr = {8'h12, 8'h11, 8'h10};
    req = 3'b111;
    serve(2, 8'h40, g);
    chk("t2_g0", 32'(g), 32'b001);
    chk("t2_a0", 32'(bus_addr), 32'h10);
    serve(3, 8'h41, g);
    chk("t2_g1", 32'(g), 32'b010);
    chk("t2_a1", 32'(bus_addr), 32'h11);
    serve(1, 8'h42, g);
    chk("t2_g2", 32'(g), 32'b100);
    chk("t2_a2", 32'(bus_addr), 32'h12);
    serve(2, 8'h43, g);
    req = 3'b000;
    chk("t2_g3", 32'(g), 32'b001);
    chk("t2_rdata", 32'(rdata), 32'h43);
    wait_idle("t2_idle");

    // 3. Timeout write from requester 1; err arrives 1024 cycles after the strobe cycle
    req = 3'b010;
    wr = 3'b010;
    addr[15:8] = RtcAddrCtrl;
    wdata[15:8] = 8'hA5;
    wait_start("t3_start");
    chk("t3_wr", 32'(bus_wr), 32'd1);
    chk("t3_wdata", 32'(bus_wdata), 32'hA5);
    step();
    addr[15:8] = 8'h00;
    wr = 3'b000;
    n = 1;
    while (err === 3'b000 && ack === 3'b000 && n < 1100) begin
      step();
      n++;
    end
    req = 3'b000;
    chk("t3_latency", 32'(n), 32'd1024);
    chk("t3_err", 32'(err), 32'b010);
    chk("t3_noack", 32'(ack), 32'd0);
    chk("t3_rdata", 32'(rdata), 32'h43);
    chk("t3_addr_held", 32'(bus_addr), 32'hF0);
    wait_idle("t3_idle");
    req = 3'b001;
    addr[7:0] = RtcAddrMinutes;
    serve(4, 8'h5A, g);
    req = 3'b000;
    chk("t3_next_g", 32'(g), 32'b001);
    chk("t3_next_rdata", 32'(rdata), 32'h5A);
    wait_idle("t3_next_idle");

    // 4. Done on the expiry cycle (1023rd wait cycle) wins
    req = 3'b100;
    wait_start("t4_start");
    chk("t4_gnt", 32'(gnt), 32'b100);
    repeat (1023) step();
    chk("t4_noerr_yet", 32'(err), 32'd0);
    bus_done = 1'b1;
    bus_rdata = 8'h66;
    step();
    bus_done = 1'b0;
    req = 3'b000;
    chk("t4_ack", 32'(ack), 32'b100);
    chk("t4_noerr", 32'(err), 32'd0);
    chk("t4_rdata", 32'(rdata), 32'h66);
    step();
    chk("t4_noerr_after", 32'(err), 32'd0);
    wait_idle("t4_idle");

    // 5. Withdrawn request and stray done
    g0 = g2_cnt;
    req = 3'b001;
    wait_start("t5_start");
    step();
    req = 3'b101;
    step();
    req = 3'b001;
    step();
    bus_done = 1'b1;
    bus_rdata = 8'h77;
    step();
    bus_done = 1'b0;
    req = 3'b000;
    chk("t5_ack", 32'(ack), 32'b001);
    wait_idle("t5_idle");
    s0 = start_cnt;
    repeat (3) step();
    bus_done = 1'b1;
    bus_rdata = 8'hFF;
    step();
    bus_done = 1'b0;
    step();
    chk("t5_g2_never", 32'(g2_cnt - g0), 32'd0);
    chk("t5_nostart", 32'(start_cnt - s0), 32'd0);
    chk("t5_rdata_keep", 32'(rdata), 32'h77);
    chk("t5_noack", 32'(ack), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);

    // 6. Reset in WAIT, then pointer restarts at requester 0's predecessor
    req = 3'b010;
    wait_start("t6_start");
    step();
    step();
    reset = 1'b0;
    #1;
    chk("t6_gnt", 32'(gnt), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_addr", 32'(bus_addr), 32'd0);
    chk("t6_rdata", 32'(rdata), 32'd0);
    chk("t6_ackerr", 32'({ack, err}), 32'd0);
    step();
    reset = 1'b1;
    req = 3'b110;
    step();
    chk("t6_first", 32'(gnt), 32'b010);
    req = 3'b000;

    chk("onehot", 32'(viol_cnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
